// File: rtl/hamming_secded_codec.sv
// Parametrised SECDED Hamming codec: encode, inject error mask, decode/correct in a 3-stage pipeline.
// Define HAMMING_ERR_COUNT_EN to build the corrected/uncorrectable statistics counters.
module hamming_secded_codec #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned P = (DATA_W <= 4) ? 3 : (DATA_W <= 11) ? 4 :
                                (DATA_W <= 26) ? 5 : 6,
    localparam int unsigned CODE_W = DATA_W + P + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] iData,
    input  logic              iValid,
    output logic              oReady,
    input  logic [CODE_W-1:0] iErr,
    input  logic              iReady,
    output logic [DATA_W-1:0] decData,
    output logic              decValid,
    output logic              decSingle,
    output logic              decDouble,
    output logic [P-1:0]      decErrPos,
    input  logic              cntClr,
    output logic [CNT_W-1:0]  corrCnt,
    output logic [CNT_W-1:0]  uncorrCnt
);

    localparam logic [P-1:0] MaxPos = P'(CODE_W - 1);

    // XOR of the indices of all set bits in positions 1..CODE_W-1
    function automatic logic [P-1:0] syndrome(input logic [CODE_W-1:0] cw);
        logic [P-1:0] s;
        s = '0;
        for (int i = 1; i < int'(CODE_W); i++) begin
            if (cw[i]) s = s ^ P'(i);
        end
        return s;
    endfunction

    function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] cw;
        logic [P-1:0]      s;
        int                j;
        cw = '0;
        j  = 0;
        for (int i = 1; i < int'(CODE_W); i++) begin
            if ((i & (i - 1)) != 0) begin
                cw[i] = d[j];
                j++;
            end
        end
        // Parity bit 2^k takes the data-only syndrome bit k, zeroing the full syndrome
        s = syndrome(cw);
        for (int k = 0; k < int'(P); k++) begin
            cw[1 << k] = s[k];
        end
        cw[0] = ^cw[CODE_W-1:1];
        return cw;
    endfunction

    function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] cw);
        logic [DATA_W-1:0] d;
        int                j;
        d = '0;
        j = 0;
        for (int i = 1; i < int'(CODE_W); i++) begin
            if ((i & (i - 1)) != 0) begin
                d[j] = cw[i];
                j++;
            end
        end
        return d;
    endfunction

    logic              adv;
    logic              s1ValidQ;
    logic [CODE_W-1:0] s1CodeQ;
    logic              s2ValidQ;
    logic [CODE_W-1:0] s2CodeQ;
    logic [P-1:0]      s2SynQ;
    logic              s2ParQ;

    logic              isSingle;
    logic              isDouble;
    logic [CODE_W-1:0] flipMask;
    logic [DATA_W-1:0] fixData;
    logic [P-1:0]      fixPos;

    assign adv    = ~decValid | iReady;
    assign oReady = adv;

    always_comb begin
        isSingle = 1'b0;
        isDouble = 1'b0;
        flipMask = '0;
        isSingle = s2ParQ && (s2SynQ <= MaxPos);
        isDouble = (!s2ParQ && (s2SynQ != '0)) || (s2ParQ && (s2SynQ > MaxPos));
        if (isSingle) flipMask = CODE_W'(1) << s2SynQ;
        fixData = extract(s2CodeQ ^ flipMask);
        fixPos  = isSingle ? s2SynQ : '0;
    end

    // Whole pipeline advances together; a stalled output freezes every stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1ValidQ  <= 1'b0;
            s1CodeQ   <= '0;
            s2ValidQ  <= 1'b0;
            s2CodeQ   <= '0;
            s2SynQ    <= '0;
            s2ParQ    <= 1'b0;
            decValid  <= 1'b0;
            decData   <= '0;
            decSingle <= 1'b0;
            decDouble <= 1'b0;
            decErrPos <= '0;
        end else if (adv) begin
            s1ValidQ  <= iValid;
            s1CodeQ   <= encode(iData) ^ iErr;
            s2ValidQ  <= s1ValidQ;
            s2CodeQ   <= s1CodeQ;
            s2SynQ    <= syndrome(s1CodeQ);
            s2ParQ    <= ^s1CodeQ;
            decValid  <= s2ValidQ;
            decData   <= fixData;
            decSingle <= isSingle;
            decDouble <= isDouble;
            decErrPos <= fixPos;
        end
    end

`ifdef HAMMING_ERR_COUNT_EN
    logic outTake;
    assign outTake = decValid & iReady;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corrCnt   <= '0;
            uncorrCnt <= '0;
        end else if (cntClr) begin
            corrCnt   <= '0;
            uncorrCnt <= '0;
        end else if (outTake) begin
            if (decSingle && !(&corrCnt))   corrCnt   <= corrCnt + 1'b1;
            if (decDouble && !(&uncorrCnt)) uncorrCnt <= uncorrCnt + 1'b1;
        end
    end
`else
    logic unusedCntClr;
    assign unusedCntClr = cntClr;
    assign corrCnt      = '0;
    assign uncorrCnt    = '0;
`endif

endmodule

// File: doc/hamming_secded_codec.md
Name: hamming_secded_codec

Overview:
Parametrised SECDED Hamming codec with a valid/ready handshake. It encodes DATA_W-bit words, XORs in a test error mask, then decodes, corrects and reports each word. It is the next generation of the fixed 16-bit Hamming block, used for link/memory ECC bring-up and fault-injection tests. Adds double-error detection, a pipelined datapath with backpressure, and error statistics.

Parameters:
DATA_W, 16, data word width (4..57)
P, derived, smallest P with 2^P >= DATA_W+P+1 (5 for DATA_W=16); localparam
CODE_W, derived, DATA_W+P+1 (22 for DATA_W=16); localparam
CNT_W, 16, width of error statistic counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
iData  in  DATA_W  data word to encode
iValid  in  1  iData/iErr valid
oReady  out  1  codec accepts input this cycle
iErr  in  CODE_W  error-injection mask, bit i flips codeword position i
iReady  in  1  downstream ready for decoded word
decData  out  DATA_W  decoded (corrected) data
decValid  out  1  decoded word valid
decSingle  out  1  single-bit error corrected
decDouble  out  1  uncorrectable error detected
decErrPos  out  P  syndrome/position of corrected bit (0 when none)
cntClr  in  1  synchronous clear of statistics counters
corrCnt  out  CNT_W  count of corrected words
uncorrCnt  out  CNT_W  count of uncorrectable words

Behaviour:
- Reset (async, rst=1): all stage valids and decValid=0; decData, decSingle, decDouble, decErrPos, corrCnt and uncorrCnt all 0. In-flight words are dropped.
- Codeword layout:
  - Positions 1..CODE_W-1 use standard Hamming placement. Parity bits sit at power-of-two positions.
  - Data bits fill the non-power positions in ascending order, iData[0] first.
  - Position 0 holds the overall even parity over positions 1..CODE_W-1.
- Pipeline: 3 stages, with a global advance enable adv = ~decValid | iReady.
  - S1: encode, then XOR with iErr.
  - S2: compute syndrome s (P bits) and overall parity q.
  - S3: correct and drive the output registers.
- oReady = adv (combinational from iReady and decValid).
- Transfer in: iValid & oReady at edge E. The decoded word appears with decValid=1 after edge E+2, provided iReady held 1.
- Transfer out: decValid & iReady. Outputs hold stable while decValid=1 & iReady=0.
- Bubbles propagate as invalid stages. With iReady=0, up to 3 words are held with no loss and no reorder.
- Decode rules:
  - s=0, q=0: clean. decSingle=0, decDouble=0, decErrPos=0.
  - q=1, s<=CODE_W-1: flip position s (s=0 means the overall parity bit). decSingle=1, decErrPos=s.
  - q=0, s!=0: decDouble=1, decData = uncorrected extracted data, decErrPos=0.
  - q=1, s>CODE_W-1 (invalid position): decDouble=1, no correction.
- Status flags are only meaningful while decValid=1. They are registered together with decData.
- Counters update on out-transfer:
  - corrCnt increments on decSingle; uncorrCnt increments on decDouble.
  - Both saturate at all-ones.
  - cntClr has priority over a simultaneous increment.
- Reset mid-operation: everything clears immediately. The first accepted word after reset behaves as above.

Optional Feature:
HAMMING_ERR_COUNT_EN
- Defined: corrCnt and uncorrCnt counters are implemented as described.
- Undefined: counter logic is omitted. corrCnt and uncorrCnt are tied to 0, cntClr is ignored, and the ports remain present.

Test Plan:
- rst pulse 100 ns; iData=16'h443D, iErr=0, iReady=1 -> 2 cycles after acceptance: decData=16'h443D, decSingle=0, decDouble=0, decErrPos=0.
- iData=16'h443D, iErr=22'd32 (position 5) -> decData=16'h443D, decSingle=1, decErrPos=5, corrCnt=1.
- iErr=22'h000001 (overall parity bit) -> decData unchanged, decSingle=1, decErrPos=0; iErr=22'h000048 (positions 3 and 6) -> decDouble=1, decSingle=0, uncorrCnt=1.
- iReady=0 while sending 16'h0001, 16'h0002, 16'h0003, 16'h0004 back-to-back:
  - oReady drops after 3 accepted; 4th held by source.
  - Outputs stable over 5 stalled cycles.
  - After iReady=1: 0001..0004 emerge in order, none lost.
- Assert rst with 2 words in flight -> decValid=0 and counters 0 immediately (asynchronous); next word decodes correctly.
- 65540 single-error words with CNT_W=16 -> corrCnt saturates at 16'hFFFF; cntClr coincident with a transfer -> corrCnt=0. With HAMMING_ERR_COUNT_EN undefined -> counters read 0 throughout.
